// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types, defaults and window helpers for pattern_detect
package pattern_pkg;

    localparam int CW_DEF = 32;
    localparam int RW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEAS_OFF,
        MEAS_ON,
        DONE
    } state_e;

    // Upper window bound: nominal + tolerance, clamped to the largest cw-bit value.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int cw);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << cw) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

    // Lower window bound: nominal - tolerance, clamped at zero.
    function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b);
        return (a > b) ? (a - b) : 64'd0;
    endfunction

endpackage

// File: rtl/pattern_detect_sync_edge.sv
// rtl/pattern_detect_sync_edge.sv - two-flop sensor synchronizer with edge detect
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    // Synchronize the raw level, then keep one more copy to spot transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign s    = s2_q;
    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/pattern_detect.sv
// rtl/pattern_detect.sv - measures sensor off/on phases and judges a blink pattern
module pattern_detect
    import pattern_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          hwclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          sense,
    input  logic [CW-1:0] ontime,
    input  logic [CW-1:0] offtime,
    input  logic [CW-1:0] tol,
    input  logic [RW-1:0] reps,
    output logic          done,
    output logic          match,
    output logic [RW-1:0] seen
);

    logic          s;
    logic          rise;
    logic          fall;

    state_e        state_q;
    logic [CW-1:0] on_q;
    logic [CW-1:0] off_q;
    logic [CW-1:0] tol_q;
    logic [RW-1:0] reps_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [RW-1:0] seen_q;
    logic [RW-1:0] seen_d;
    logic          done_q;
    logic          match_q;

    logic [CW-1:0] nom;
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;

    sync_edge u_sync (
        .clk   (hwclk),
        .rst_n (rst_n),
        .d     (sense),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    // The acceptance window follows whichever phase is currently being timed.
    assign nom    = (state_q == MEAS_ON) ? on_q : off_q;
    assign lo     = CW'(sat_sub(64'(nom), 64'(tol_q)));
    assign hi     = CW'(sat_add(64'(nom), 64'(tol_q), CW));
    assign cnt_d  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    assign seen_d = seen_q + RW'(1);

    // Detector FSM: arm, time each phase, compare with the window, hold the verdict.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            on_q    <= '0;
            off_q   <= '0;
            tol_q   <= '0;
            reps_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seen_q  <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    on_q    <= ontime;
                    off_q   <= offtime;
                    tol_q   <= tol;
                    reps_q  <= reps;
                    seen_q  <= '0;
                    done_q  <= 1'b0;
                    match_q <= 1'b0;
                    state_q <= ARM;
                end
                ARM: begin
                    if (reps_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        match_q <= 1'b1;
                    end else if (!s) begin
                        state_q <= MEAS_OFF;
                        cnt_q   <= CW'(1);
                    end
                end
                MEAS_OFF: begin
                    // A count past the upper bound loses even if the edge arrives now.
                    if (cnt_q > hi) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        match_q <= 1'b0;
                    end else if (rise) begin
                        if (cnt_q >= lo) begin
                            state_q <= MEAS_ON;
                            cnt_q   <= CW'(1);
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            match_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                MEAS_ON: begin
                    if (cnt_q > hi) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        match_q <= 1'b0;
                    end else if (fall) begin
                        if (cnt_q >= lo) begin
                            seen_q <= seen_d;
                            if (seen_d == reps_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                match_q <= 1'b1;
                            end else begin
                                state_q <= MEAS_OFF;
                                cnt_q   <= CW'(1);
                            end
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            match_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done  = done_q;
    assign match = match_q;
    assign seen  = seen_q;

endmodule

// File: tb/tb_pattern_detect.sv
// tb/tb_pattern_detect.sv - randomized self-checking bench for pattern_detect
module tb_pattern_detect;

    localparam longint MAXV = 64'hFFFF_FFFF;

    logic        hwclk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sense;
    logic [31:0] ontime;
    logic [31:0] offtime;
    logic [31:0] tol;
    logic [7:0]  reps;
    logic        done;
    logic        match;
    logic [7:0]  seen;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_off, m_on, m_tol, m_reps;
    int     phases[$];

    pattern_detect dut (
        .hwclk   (hwclk),
        .rst_n   (rst_n),
        .enable  (enable),
        .sense   (sense),
        .ontime  (ontime),
        .offtime (offtime),
        .tol     (tol),
        .reps    (reps),
        .done    (done),
        .match   (match),
        .seen    (seen)
    );

    always #5 hwclk = ~hwclk;

    // Raw sensor level at cycle i: phases alternate low/high starting low, last level holds.
    function automatic logic wave_at(input int i);
        int acc;
        acc = 0;
        for (int p = 0; p < phases.size(); p++) begin
            acc += phases[p];
            if (i < acc) return (p % 2) == 1;
        end
        return ((phases.size() - 1) % 2) == 1;
    endfunction

    // Reference: walk the phase list against the windows; ev is the cycle index (in
    // measured phase time) of the deciding event, the verdict registers 2 cycles later.
    task automatic model(input int shift, output int ev, output bit pass, output int nseen);
        longint lo, hi, nom, len, t;
        t = 0; nseen = 0; pass = 0; ev = 0;
        for (int p = 0; p < 1000; p++) begin
            nom = (p % 2 == 0) ? m_off : m_on;
            lo  = (nom > m_tol) ? nom - m_tol : 0;
            hi  = (nom + m_tol > MAXV) ? MAXV : nom + m_tol;
            len = (p < phases.size()) ? longint'(phases[p]) : longint'(1 << 30);
            if (p == 0) len += shift;
            if (len < lo) begin ev = int'(t + len); return; end
            if (len > hi) begin ev = int'(t + hi + 1); return; end
            t += len;
            if (p % 2 == 1) begin
                nseen++;
                if (nseen == m_reps) begin pass = 1; ev = int'(t); return; end
            end
        end
    endtask

    task automatic arm(input longint off, input longint on, input longint t, input longint r);
        @(negedge hwclk);
        enable = 1'b0; sense = 1'b1;
        repeat (2) @(negedge hwclk);
        offtime = 32'(off); ontime = 32'(on); tol = 32'(t); reps = 8'(r);
        m_off = off; m_on = on; m_tol = t; m_reps = r;
        enable = 1'b1;
        repeat (3) @(negedge hwclk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL arm_wait_done: got %0b expected 0", done); end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin sense = v; @(negedge hwclk); end
    endtask

    task automatic drive_check(input string name, input int shift);
        int ev, exp_seen, exp_edge, got_edge;
        bit exp_match;
        model(shift, ev, exp_match, exp_seen);
        exp_edge = ev + 2 - shift;
        got_edge = -1;
        for (int i = 0; i < exp_edge + 8 && got_edge < 0; i++) begin
            sense = wave_at(i);
            @(posedge hwclk); #1;
            if (done === 1'b1) got_edge = i;
        end
        n_checks++;
        if (got_edge != exp_edge) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, got_edge, exp_edge); end
        n_checks++;
        if (match !== exp_match) begin n_fail++; $display("FAIL %s_match: got %0b expected %0b", name, match, exp_match); end
        n_checks++;
        if (seen !== 8'(exp_seen)) begin n_fail++; $display("FAIL %s_seen: got %0d expected %0d", name, seen, exp_seen); end
        for (int j = 1; j <= 3; j++) begin
            sense = wave_at(exp_edge + j);
            @(posedge hwclk); #1;
            n_checks++;
            if (done !== 1'b1 || match !== exp_match) begin
                n_fail++;
                $display("FAIL %s_hold: got done=%0b match=%0b expected done=1 match=%0b", name, done, match, exp_match);
            end
        end
        @(negedge hwclk);
        enable = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; sense = 1'b0;
        offtime = '0; ontime = '0; tol = '0; reps = '0;
        repeat (3) @(posedge hwclk);
        #1;
        n_checks++;
        if (done !== 1'b0 || match !== 1'b0 || seen !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%0b match=%0b seen=%0d expected 0 0 0", done, match, seen);
        end
        @(negedge hwclk);
        rst_n = 1'b1;
        @(negedge hwclk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_idle_done: got %0b expected 0", done); end
    endtask

    task automatic test_exact;
        arm(3, 5, 0, 2);
        phases = '{3, 5, 3, 5, 40};
        drive_check("exact", 0);
    endtask

    task automatic test_tolerance;
        arm(3, 5, 1, 1);
        phases = '{2, 5, 40};
        drive_check("tol_low2", 0);
        arm(3, 5, 1, 1);
        phases = '{4, 5, 40};
        drive_check("tol_low4", 0);
        arm(3, 5, 1, 1);
        phases = '{1, 5, 40};
        drive_check("tol_low1", 0);
    endtask

    task automatic test_saturation;
        arm(2, 4, 5, 1);
        phases = '{1, 9, 40};
        drive_check("sat_lower", 0);
        arm(3, 4, MAXV, 1);
        phases = '{5, 6, 40};
        drive_check("sat_upper", 0);
    endtask

    task automatic test_timeout;
        arm(3, 5, 0, 2);
        phases = '{3, 5, 3, 100};
        drive_check("timeout_high", 0);
        arm(3, 5, 0, 2);
        phases = '{7, 40};
        drive_check("timeout_low", 0);
    endtask

    task automatic test_reps_zero;
        @(negedge hwclk);
        enable = 1'b0; sense = 1'($urandom_range(0, 1)); reps = 8'd0;
        @(negedge hwclk);
        enable = 1'b1;
        repeat (2) @(posedge hwclk);
        #1;
        n_checks++;
        if (done !== 1'b1 || match !== 1'b1) begin
            n_fail++;
            $display("FAIL reps_zero: got done=%0b match=%0b expected 1 1", done, match);
        end
        @(negedge hwclk);
        enable = 1'b0;
    endtask

    task automatic test_enable_drop;
        arm(3, 5, 0, 2);
        drive(1'b0, 3); drive(1'b1, 5); drive(1'b0, 3); drive(1'b1, 2);
        n_checks++;
        if (seen !== 8'd1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_before: got seen=%0d done=%0b expected 1 0", seen, done);
        end
        enable = 1'b0;
        @(posedge hwclk); #1;
        n_checks++;
        if (done !== 1'b0 || match !== 1'b0 || seen !== 8'd0) begin
            n_fail++;
            $display("FAIL drop_clear: got done=%0b match=%0b seen=%0d expected 0 0 0", done, match, seen);
        end
        arm(3, 7, 0, 1);
        phases = '{3, 7, 40};
        drive_check("drop_rearm", 0);
    endtask

    task automatic test_reset_mid;
        arm(4, 3, 0, 2);
        drive(1'b0, 4); drive(1'b1, 3); drive(1'b0, 3);
        n_checks++;
        if (seen !== 8'd1) begin n_fail++; $display("FAIL rstmid_before: got seen=%0d expected 1", seen); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || match !== 1'b0 || seen !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got done=%0b match=%0b seen=%0d expected 0 0 0", done, match, seen);
        end
        sense = 1'b0;
        @(negedge hwclk);
        rst_n = 1'b1;
        // Synchronizer restarts low, so the cycle right after arming already counts as low.
        phases = '{3, 3, 3, 3, 40};
        drive_check("rstmid_restart", 1);
    endtask

    task automatic test_random;
        longint off, on, t, r, nom;
        int v;
        for (int k = 0; k < 25; k++) begin
            off = $urandom_range(2, 6);
            on  = $urandom_range(2, 6);
            t   = $urandom_range(0, 2);
            r   = $urandom_range(1, 4);
            arm(off, on, t, r);
            phases = {};
            for (int p = 0; p < 2 * r; p++) begin
                nom = (p % 2 == 0) ? off : on;
                if ($urandom_range(0, 3) != 0)
                    v = int'(nom - t) + int'($urandom_range(0, 32'(2 * t)));
                else if ($urandom_range(0, 1) == 1)
                    v = int'(nom + t + 1);
                else
                    v = int'(nom - t - 1);
                if (v < 1) v = 1;
                phases.push_back(v);
            end
            phases.push_back(40);
            drive_check($sformatf("rand%0d", k), 0);
        end
    endtask

    initial begin
        test_reset;
        test_exact;
        test_tolerance;
        test_saturation;
        test_timeout;
        test_reps_zero;
        test_enable_drop;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detect.md
# pattern_detect

Receive-side counterpart of the LED blink `pattern` generator. It watches a light-sensor input for a train of off/on pulses and measures each low and high phase in clock cycles. Each phase is checked against expected durations within a tolerance, and the block counts the good repetitions. It reports `done` when a verdict is reached and `match` when the whole pattern was reproduced. It sits between the sensor pad and the keylock decision logic.

## Interface
- `CW`, 32: phase counter and duration width.
- `RW`, 8: repetition count width.

- `hwclk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  arm detector; low aborts and clears the verdict
- `sense`  in  1  raw sensor level (asynchronous, 1 = light)
- `ontime`  in  CW  expected high-phase length, cycles
- `offtime`  in  CW  expected low-phase length, cycles
- `tol`  in  CW  allowed ± deviation per phase, cycles
- `reps`  in  RW  required number of off+on cycles
- `done`  out  1  verdict valid
- `match`  out  1  pattern accepted (valid only with `done`)
- `seen`  out  RW  good repetitions counted so far

## Operation
- `sense` passes through a 2-flop synchronizer. Rise and fall are detected on the synchronized signal `s`.
- States:
  - IDLE: `enable` high → latch `ontime`, `offtime`, `tol` and `reps`; clear `seen`; go to ARM.
  - ARM: if latched `reps`==0 → DONE with `match`=1. Else if `s`==0 → MEAS_OFF with `cnt`=1. Else wait, since the first measured phase must be a low.
  - MEAS_OFF: `cnt`++ while low.
    - On rise: if `offtime`−`tol` ≤ `cnt` ≤ `offtime`+`tol` → MEAS_ON with `cnt`=1; else → DONE with `match`=0.
    - If `cnt` > `offtime`+`tol` while still low (timeout) → DONE with `match`=0.
  - MEAS_ON: same checks against `ontime`.
    - On a good fall: `seen`++. If new `seen`==`reps` → DONE with `match`=1; else → MEAS_OFF with `cnt`=1.
  - DONE: `done`=1, `match` held. Stays here while `enable` is high.
- `enable` low in any state → IDLE next cycle, with `done`, `match` and `seen` cleared.
- Window arithmetic:
  - Bounds are computed in CW+1 bits.
  - Lower bound saturates at 0; upper bound saturates at 2^CW−1.
  - `cnt` saturates at 2^CW−1 and never wraps.
- Inputs are sampled only on the IDLE→ARM transition; later changes are ignored until the next arm.

## Timing
- Reset values: state IDLE, `done`=0, `match`=0, `seen`=0, `cnt`=0, synchronizer flops 0.
- Sensor-to-detection latency is 2 cycles, equal on both edges, so measured phase lengths equal true lengths exactly.
- The edge cycle counts as cycle 1 of the new phase.
- Verdict latency:
  - Good pattern: `done` rises 1 cycle after the synchronized final fall, i.e. 3 cycles after the raw fall.
  - Timeout: `done` rises 1 cycle after `cnt` exceeds the upper bound.
- Simultaneous edge and timeout in the same cycle: timeout wins, giving fail.
- `done`, `match` and `seen` are registered outputs with no combinational path from inputs.
- Asynchronous reset mid-operation returns to the reset values immediately. After release, a new arm requires `enable` high.

## Structure
- Shared package `pattern_pkg`: state enum (IDLE, ARM, MEAS_OFF, MEAS_ON, DONE), `CW`/`RW` defaults, saturating-bound helper function.
- Sub-module `sync_edge`: 2-flop synchronizer plus registered-previous edge detect. Outputs are `s`, `rise` and `fall`; reset is `rst_n`.
- The FSM, latch registers, `cnt`, `seen` and window compare live in `pattern_detect`.

## Test plan
- Exact pattern: `offtime`=3, `ontime`=5, `tol`=0, `reps`=2, sense low 3 / high 5 ×2 then low → `done`=1, `match`=1, `seen`=2, 3 cycles after the last raw fall.
- Tolerance edges: `tol`=1, low phase of 2 then 4 in consecutive runs → both accepted. Low phase of 1 → `done`=1, `match`=0, `seen`=0.
- Timeout: `ontime`=5, `tol`=0, sense held high 7 cycles → `done` while still high, `match`=0, `seen` equal to completed reps.
- `reps`=0 with `enable` raised → `done`=1, `match`=1 within 2 cycles, independent of `sense`.
- `enable` dropped mid MEAS_ON, then re-raised with a new `ontime` → flags clear next cycle; the new value is used on the fresh run.
- `rst_n` pulsed low mid MEAS_OFF → all outputs 0 immediately. After release with `enable` high, the sequence restarts from ARM.
